uart_tx_arbiter: RTL
====================

// Module: uart_tx_arbiter
// PURPOSE
//  Round-robin, message-granular arbiter sharing one uart_tx between NREQ byte-stream requesters.
//  Sits between several message sources (per-source fsm) and the single uart_tx instance.
//  A grant is held for a whole message (through the byte flagged last), so messages never interleave.
//  Sequences each byte into uart_tx via the uart_tx_en/uart_tx_busy handshake.
// PARAMETERS
//  NREQ          4          number of requesters (2..8)
//  PAYLOAD_BITS  8          byte width, matches uart_tx PAYLOAD_BITS
//  TIMEOUT_CYC   1_000_000  stall limit in LOAD (used only with UART_ARB_TIMEOUT_EN)
// PORTS
//  clk           in   1                  system clock
//  resetn        in   1                  synchronous, active-low reset
//  req           in   NREQ               requester i has a message pending
//  req_valid     in   NREQ               requester i presents a byte on its req_data slice
//  req_data      in   NREQ*PAYLOAD_BITS  packed; requester i at [i*PAYLOAD_BITS +: PAYLOAD_BITS]
//  req_last      in   NREQ               presented byte is the last of the message
//  req_ready     out  NREQ               one-hot 1-cycle pulse: byte of requester i accepted
//  grant         out  NREQ               one-hot current owner, 0 when idle
//  uart_tx_busy  in   1                  from uart_tx
//  uart_tx_en    out  1                  1-cycle pulse to uart_tx
//  uart_tx_data  out  PAYLOAD_BITS       byte to uart_tx, stable from en until next load
//  state         out  2                  FSM state (for LED display)
//  arb_timeout   out  1                  1-cycle pulse on grant revoked by timeout
// BEHAVIOUR
//  - All outputs registered. Reset (resetn=0 at a clk edge): state=IDLE, grant=0, req_ready=0,
//    uart_tx_en=0, uart_tx_data=0, arb_timeout=0, pointer ptr=0. Reset mid-message aborts it;
//    uart_tx shares resetn so the in-flight byte is aborted too. No partial-message resume.
//  - States: IDLE=0, LOAD=1, WAIT_BUSY=2, WAIT_DONE=3.
//  - IDLE: if |req, pick first set req scanning ptr, ptr+1, ... mod NREQ; grant<=onehot(g); ->LOAD.
//    Grant visible 1 cycle after req sampled.
//  - LOAD: if req_valid[g] && !uart_tx_busy: uart_tx_data<=slice g, uart_tx_en<=1, req_ready[g]<=1
//    (both pulse exactly 1 cycle), last_q<=req_last[g]; ->WAIT_BUSY.
//    Else if !req[g] (requester withdrew): grant<=0, ptr<=g+1 mod NREQ; ->IDLE.
//  - WAIT_BUSY: wait for uart_tx_busy=1; ->WAIT_DONE. Never issues en here.
//  - WAIT_DONE: on uart_tx_busy=0: if last_q: grant<=0, ptr<=g+1 mod NREQ, ->IDLE; else ->LOAD.
//  - Latency: req high at cycle 0 -> grant cycle 1 -> en/ready cycle 2 (if valid at cycle 1).
//    Inter-byte: busy falls at cycle k -> LOAD at k+1 -> next en at k+2.
//  - Fairness: after any release, the just-served requester has lowest priority; a requester
//    cannot win twice in a row while another req is high. req changes of non-owners are ignored
//    until IDLE. req_valid/data of non-owners are ignored; req_ready of non-owners stays 0.
//  - Requester contract: hold data/last stable while valid until ready; advance the cycle after ready.
//  - NREQ=1 degenerates to a pass-through sequencer (ptr stays 0).
// CONFIGURATION
//  UART_ARB_TIMEOUT_EN defined: counter counts consecutive LOAD cycles without req_valid[g];
//    at TIMEOUT_CYC cycles: grant<=0, ptr<=g+1 mod NREQ, arb_timeout<=1 (1 cycle), ->IDLE.
//    Counter clears on entering LOAD and on each accepted byte.
//  Not defined: no counter, arb_timeout tied 0, owner may stall LOAD indefinitely.
// TESTING  (NREQ=4, PAYLOAD_BITS=8, bench uart_tx model: busy high 10 cycles starting the cycle after en)
//  1 reset: resetn=0 for 3 cycles mid-byte -> all outputs 0, state=0 one cycle after first low edge.
//  2 single msg: req0 sends 0x57,0x61(last) -> two en pulses carrying 0x57 then 0x61, grant=0001
//    throughout, back to IDLE, ptr=1; en at cycle 2, second en 2 cycles after busy falls.
//  3 contention: req0..req3 all high, each 2-byte msg, ptr=0 -> grant order 0,1,2,3; no interleaving.
//  4 fairness: req0 and req2 always pending, ptr=1 -> order 2,0,2,0; req0 never served twice in a row.
//  5 withdraw: grant to req1, req1 drops with req_valid=0 in LOAD -> grant=0 next cycle, no en, ptr=2.
//  6 timeout (UART_ARB_TIMEOUT_EN, TIMEOUT_CYC=50): owner sends 1 byte, then no valid 50 cycles
//    -> arb_timeout pulse, grant revoked, next requester granted; without macro grant still held at 500.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and uart_tx-side signal bundle of uart_tx_arbiter.
// master = arbiter side, slave = requesters plus uart_tx (or a bench standing in for them).
interface uart_tx_arbiter_if #(
  parameter int NREQ         = 4,
  parameter int PAYLOAD_BITS = 8
);
  logic [NREQ-1:0]                   req;
  logic [NREQ-1:0]                   req_valid;
  logic [NREQ-1:0][PAYLOAD_BITS-1:0] req_data;
  logic [NREQ-1:0]                   req_last;
  logic [NREQ-1:0]                   req_ready;
  logic [NREQ-1:0]                   grant;
  logic                              uart_tx_busy;
  logic                              uart_tx_en;
  logic [PAYLOAD_BITS-1:0]           uart_tx_data;
  logic [1:0]                        state;
  logic                              arb_timeout;

  modport master (
    input  req, req_valid, req_data, req_last, uart_tx_busy,
    output req_ready, grant, uart_tx_en, uart_tx_data, state, arb_timeout
  );

  modport slave (
    output req, req_valid, req_data, req_last, uart_tx_busy,
    input  req_ready, grant, uart_tx_en, uart_tx_data, state, arb_timeout
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-granular arbiter sharing one uart_tx between NREQ byte streams.
// Define UART_ARB_TIMEOUT_EN to revoke a grant after TIMEOUT_CYC stalled LOAD cycles.
module uart_tx_arbiter #(
  parameter int NREQ         = 4,
  parameter int PAYLOAD_BITS = 8,
  parameter int TIMEOUT_CYC  = 1_000_000
) (
  input  logic               clk,
  input  logic               resetn,
  uart_tx_arbiter_if.master  bus
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] LOAD      = 2'd1;
  localparam logic [1:0] WAIT_BUSY = 2'd2;
  localparam logic [1:0] WAIT_DONE = 2'd3;

  logic [1:0]    st;
  logic [PW-1:0] ptr, gidx, gnext, pick, idx;
  logic          found, last_q, to_hit;

  assign bus.state = st;
  assign gnext     = PW'((int'(gidx) + 1) % NREQ);

  // First pending requester at or after ptr, wrapping.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = PW'((int'(ptr) + k) % NREQ);
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] to_cnt;

  // Counts only consecutive stalled LOAD cycles; any other state holds it at 0.
  always_ff @(posedge clk) begin
    if (!resetn || st != LOAD || bus.req_valid[gidx]) to_cnt <= '0;
    else                                              to_cnt <= to_cnt + 1'b1;
  end

  assign to_hit = (st == LOAD) && !bus.req_valid[gidx] && (to_cnt == TW'(TIMEOUT_CYC - 1));
`else
  assign to_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      st               <= IDLE;
      ptr              <= '0;
      gidx             <= '0;
      last_q           <= 1'b0;
      bus.grant        <= '0;
      bus.req_ready    <= '0;
      bus.uart_tx_en   <= 1'b0;
      bus.uart_tx_data <= '0;
      bus.arb_timeout  <= 1'b0;
    end else begin
      bus.req_ready   <= '0;
      bus.uart_tx_en  <= 1'b0;
      bus.arb_timeout <= 1'b0;
      case (st)
        IDLE: if (found) begin
          gidx      <= pick;
          bus.grant <= NREQ'(1) << pick;
          st        <= LOAD;
        end
        LOAD: begin
          if (bus.req_valid[gidx] && !bus.uart_tx_busy) begin
            bus.uart_tx_data <= bus.req_data[gidx];
            bus.uart_tx_en   <= 1'b1;
            bus.req_ready    <= NREQ'(1) << gidx;
            last_q           <= bus.req_last[gidx];
            st               <= WAIT_BUSY;
          end else if (!bus.req[gidx] || to_hit) begin
            // Owner withdrew or stalled too long: release, owner drops to lowest priority.
            bus.grant       <= '0;
            bus.arb_timeout <= to_hit && bus.req[gidx];
            ptr             <= gnext;
            st              <= IDLE;
          end
        end
        WAIT_BUSY: if (bus.uart_tx_busy) st <= WAIT_DONE;
        WAIT_DONE: if (!bus.uart_tx_busy) begin
          if (last_q) begin
            bus.grant <= '0;
            ptr       <= gnext;
            st        <= IDLE;
          end else begin
            st <= LOAD;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule
